// File: rtl/lcd_timing_pkg.sv
// Shared 640x480@60 raster constants and the RGB 4:4:4 pixel type.
package lcd_timing_pkg;

    localparam int LCD_H_SYNC  = 96;
    localparam int LCD_H_BACK  = 48;
    localparam int LCD_H_DISP  = 640;
    localparam int LCD_H_FRONT = 16;

    localparam int LCD_V_SYNC  = 2;
    localparam int LCD_V_BACK  = 33;
    localparam int LCD_V_DISP  = 480;
    localparam int LCD_V_FRONT = 10;

    // Full period of one axis: sync + back porch + active + front porch.
    function automatic int axis_total(input int sync_w, input int back_w,
                                      input int disp_w, input int front_w);
        return sync_w + back_w + disp_w + front_w;
    endfunction

    localparam int LCD_H_TOTAL = axis_total(LCD_H_SYNC, LCD_H_BACK, LCD_H_DISP, LCD_H_FRONT);
    localparam int LCD_V_TOTAL = axis_total(LCD_V_SYNC, LCD_V_BACK, LCD_V_DISP, LCD_V_FRONT);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/lcd_timing_driver_sig_delay.sv
// Fixed-depth shift register with a synchronous reset to a parameterised value.
module sig_delay #(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift d_i through DEPTH registers; reset loads every stage with RST_VAL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lcd_timing_driver.sv
// Display timing master: H/V raster counters, overlay coordinate requests,
// and panel sync/DE/RGB outputs aligned to the overlay's read latency.
module lcd_timing_driver
    import lcd_timing_pkg::*;
#(
    parameter int   H_SYNC   = LCD_H_SYNC,
    parameter int   H_BACK   = LCD_H_BACK,
    parameter int   H_DISP   = LCD_H_DISP,
    parameter int   H_FRONT  = LCD_H_FRONT,
    parameter int   V_SYNC   = LCD_V_SYNC,
    parameter int   V_BACK   = LCD_V_BACK,
    parameter int   V_DISP   = LCD_V_DISP,
    parameter int   V_FRONT  = LCD_V_FRONT,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIX_LEAD = 1,
    parameter int   CNT_W    = 11
) (
    input  logic       lcd_clk,
    input  logic       sys_rst,
    output logic [9:0] pixel_xpos,
    output logic [9:0] pixel_ypos,
    output logic       data_req,
    input  logic [3:0] pix_r,
    input  logic [3:0] pix_g,
    input  logic [3:0] pix_b,
    output logic       lcd_hs,
    output logic       lcd_vs,
    output logic       lcd_de,
    output logic [3:0] lcd_r,
    output logic [3:0] lcd_g,
    output logic [3:0] lcd_b,
    output logic       frame_start
);

    localparam int H_TOTAL = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

    if ((H_DISP > 1024) || (V_DISP > 1024)) begin : g_bad_disp
        $error("lcd_timing_driver: active area exceeds 10-bit coordinates");
    end
    if ((PIX_LEAD < 1) || (PIX_LEAD > 4)) begin : g_bad_lead
        $error("lcd_timing_driver: PIX_LEAD must be 1..4");
    end
    if ((CNT_W < 10) || (H_TOTAL >= (1 << CNT_W)) || (V_TOTAL >= (1 << CNT_W))) begin : g_bad_cnt
        $error("lcd_timing_driver: CNT_W too narrow for raster totals");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BACK + V_DISP);
    localparam logic [9:0]       H_OFF10  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]       V_OFF10  = 10'(V_SYNC + V_BACK);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic       raw_act;
    logic       req_q, req_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       fs_q, fs_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;

    logic [2:0] dl_q;
    logic       hs_q, vs_q, de_q;
    rgb444_t    rgb_q;

    // Raster counters: h wraps at end of line, v advances on the same edge.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Decode raw counter regions into the first pipeline stage.
    always_comb begin
        raw_act = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E) &&
                  (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
        req_d   = raw_act;
        x_d     = '0;
        y_d     = '0;
        if (raw_act) begin
            // Low 10 bits suffice: the offset difference stays within 0..1023 in the window.
            x_d = h_cnt_q[9:0] - H_OFF10;
            y_d = v_cnt_q[9:0] - V_OFF10;
        end
        fs_d    = raw_act && (h_cnt_q == H_ACT_S) && (v_cnt_q == V_ACT_S);
        hs1_d   = (h_cnt_q < H_SYNC_C) ? SYNC_POL : ~SYNC_POL;
        vs1_d   = (v_cnt_q < V_SYNC_C) ? SYNC_POL : ~SYNC_POL;
    end

    // Counter and stage-1 registers.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            req_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            hs1_q   <= ~SYNC_POL;
            vs1_q   <= ~SYNC_POL;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
        end
    end

    // PIX_LEAD stages cover the overlay read; the final register below adds one more.
    sig_delay #(
        .WIDTH   (3),
        .DEPTH   (PIX_LEAD),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_sync_dly (
        .clk_i (lcd_clk),
        .rst_i (sys_rst),
        .d_i   ({hs1_q, vs1_q, req_q}),
        .q_o   (dl_q)
    );

    // Panel output register: sync/DE from the delay line, RGB captured on the same edge.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            de_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= dl_q[2];
            vs_q  <= dl_q[1];
            de_q  <= dl_q[0];
            rgb_q <= dl_q[0] ? {pix_r, pix_g, pix_b} : '0;
        end
    end

    assign data_req    = req_q;
    assign pixel_xpos  = x_q;
    assign pixel_ypos  = y_q;
    assign frame_start = fs_q;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign lcd_r       = rgb_q.r;
    assign lcd_g       = rgb_q.g;
    assign lcd_b       = rgb_q.b;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver: full 800-clk lines, shortened 15-line frame.
module tb_lcd_timing_driver;

    localparam int HS = 96, HB = 48, HD = 640, HF = 16;
    localparam int VS = 2,  VB = 3,  VD = 8,   VF = 2;
    localparam int PL = 1;
    localparam int HT = HS + HB + HD + HF;   // 800
    localparam int VT = VS + VB + VD + VF;   // 15
    localparam int FRAME = HT * VT;          // 12000
    localparam int HAS = HS + HB;
    localparam int VAS = VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pixel_xpos, pixel_ypos;
    logic       data_req, frame_start;
    logic [3:0] pix_r, pix_g, pix_b;
    logic       lcd_hs, lcd_vs, lcd_de;
    logic [3:0] lcd_r, lcd_g, lcd_b;

    always #5 clk = ~clk;

    lcd_timing_driver #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .SYNC_POL(1'b0), .PIX_LEAD(PL), .CNT_W(11)
    ) dut (
        .lcd_clk(clk), .sys_rst(rst),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .data_req(data_req),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic       dreq;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       de;
    } obs_t;

    typedef struct {
        int    k;
        obs_t  e;
        string nm;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int k = 0;          // edges since reset release (0 on reset edges)
    logic sb_on = 1'b0;
    logic [11:0] sb_q [$];
    logic [11:0] ov_q [PL];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (k=%0d)", nm, got, exp, k);
        end
    endtask

    function automatic obs_t mk(input logic d, input int x, input int y,
                                input logic f, input logic h, input logic v, input logic e);
        obs_t o;
        o.dreq = d; o.x = 10'(x); o.y = 10'(y);
        o.fs = f; o.hs = h; o.vs = v; o.de = e;
        return o;
    endfunction

    function automatic obs_t get_obs();
        return mk(data_req, int'(pixel_xpos), int'(pixel_ypos), frame_start, lcd_hs, lcd_vs, lcd_de);
    endfunction

    // Overlay drawing: white box x 100..200, rows 2..5; coordinate pattern elsewhere.
    function automatic logic [11:0] ovl_col(input logic [9:0] x, input logic [9:0] y);
        if (x >= 10'd100 && x <= 10'd200 && y >= 10'd2 && y <= 10'd5)
            return 12'hFFF;
        return {x[3:0], y[3:0], x[7:4] ^ 4'h5};
    endfunction

    // Closed-form expectation of the coordinate stage after edge kk.
    function automatic obs_t model_s1(input int kk);
        int c, h, v;
        logic act;
        c = (kk - 1) % FRAME;
        h = c % HT;
        v = c / HT;
        act = (h >= HAS) && (h < HAS + HD) && (v >= VAS) && (v < VAS + VD);
        return mk(act, act ? h - HAS : 0, act ? v - VAS : 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    always @(posedge clk) k <= rst ? 0 : k + 1;

    // Overlay stimulus: PL-clk registered colour lookup.
    always @(posedge clk) begin
        ov_q[0] <= data_req ? ovl_col(pixel_xpos, pixel_ypos) : 12'h000;
        for (int i = 1; i < PL; i++) ov_q[i] <= ov_q[i-1];
    end
    assign {pix_r, pix_g, pix_b} = ov_q[PL-1];

    // Scoreboard: push expected colour for each modelled request, pop on lcd_de.
    always @(negedge clk) begin
        obs_t m;
        logic [11:0] e;
        if (k == 0) begin
            sb_q.delete();
        end else if (sb_on) begin
            m = model_s1(k);
            if (m.dreq) sb_q.push_back(ovl_col(m.x, m.y));
            if (lcd_de) begin
                if (sb_q.size() == 0) begin
                    chk("rgb_unexpected_de", 64'(lcd_de), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rgb_pixel", {52'd0, lcd_r, lcd_g, lcd_b}, {52'd0, e});
                end
            end else begin
                chk("rgb_blank", {52'd0, lcd_r, lcd_g, lcd_b}, 64'd0);
            end
        end
    end

    initial begin
        vec_t tv[$];
        obs_t rst_obs;
        int guard;
        int n_hs, n_vs, n_de, n_req, n_fs, n_hs_line, n_de_line, n_hs_edges, n_de_edges, fs_k;
        logic p_hs, p_de;
        int kd, ke;

        rst_obs = mk(0, 0, 0, 0, 1, 1, 0);

        //        k       dreq  x    y  fs hs vs de
        tv.push_back('{1,     mk(0,   0,   0, 0, 1, 1, 0), "pipe_reset_k1"});
        tv.push_back('{2,     mk(0,   0,   0, 0, 1, 1, 0), "pipe_reset_k2"});
        tv.push_back('{3,     mk(0,   0,   0, 0, 0, 0, 0), "hs_first_active"});
        tv.push_back('{98,    mk(0,   0,   0, 0, 0, 0, 0), "hs_last_active"});
        tv.push_back('{99,    mk(0,   0,   0, 0, 1, 0, 0), "hs_released"});
        tv.push_back('{1602,  mk(0,   0,   0, 0, 1, 0, 0), "vs_last_active"});
        tv.push_back('{1603,  mk(0,   0,   0, 0, 0, 1, 0), "vs_released"});
        tv.push_back('{4145,  mk(1,   0,   0, 1, 1, 1, 0), "first_pixel"});
        tv.push_back('{4146,  mk(1,   1,   0, 0, 1, 1, 0), "second_pixel"});
        tv.push_back('{4147,  mk(1,   2,   0, 0, 1, 1, 1), "de_first"});
        tv.push_back('{4784,  mk(1, 639,   0, 0, 1, 1, 1), "line_last_px"});
        tv.push_back('{4785,  mk(0,   0,   0, 0, 1, 1, 1), "req_off"});
        tv.push_back('{4787,  mk(0,   0,   0, 0, 1, 1, 0), "de_off"});
        tv.push_back('{4945,  mk(1,   0,   1, 0, 1, 1, 0), "row1_first"});
        tv.push_back('{10384, mk(1, 639,   7, 0, 1, 1, 1), "frame_last_px"});
        tv.push_back('{10387, mk(0,   0,   0, 0, 1, 1, 0), "frame_de_off"});
        tv.push_back('{12001, mk(0,   0,   0, 0, 1, 1, 0), "wrap_pre"});
        tv.push_back('{12003, mk(0,   0,   0, 0, 0, 0, 0), "wrap_sync"});
        tv.push_back('{16145, mk(1,   0,   0, 1, 1, 1, 0), "frame2_first"});

        // Reset held 5 clk: every cycle at reset values.
        repeat (5) begin
            @(negedge clk);
            chk("reset_hold", {28'd0, get_obs(), lcd_r, lcd_g, lcd_b}, {28'd0, rst_obs, 12'h000});
        end
        rst = 1'b0;
        sb_on = 1'b1;

        foreach (tv[i]) begin
            guard = 0;
            while (k < tv[i].k && guard < 30000) begin
                @(negedge clk);
                guard++;
            end
            if (k != tv[i].k) chk({"timeout_", tv[i].nm}, 64'(k), 64'(tv[i].k));
            else chk(tv[i].nm, 64'(get_obs()), 64'(tv[i].e));
        end

        // One full frame window of counts; first 800 clk cover one active line.
        n_hs = 0; n_vs = 0; n_de = 0; n_req = 0; n_fs = 0;
        n_hs_line = 0; n_de_line = 0; n_hs_edges = 0; n_de_edges = 0; fs_k = -1;
        p_hs = lcd_hs; p_de = lcd_de;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (!lcd_hs) n_hs++;
            if (!lcd_vs) n_vs++;
            if (lcd_de) n_de++;
            if (data_req) n_req++;
            if (frame_start) begin n_fs++; fs_k = k; end
            if (i < HT && !lcd_hs) n_hs_line++;
            if (i < HT && lcd_de) n_de_line++;
            if (p_hs && !lcd_hs) n_hs_edges++;
            if (!p_de && lcd_de) n_de_edges++;
            p_hs = lcd_hs; p_de = lcd_de;
        end
        sb_on = 1'b0;
        chk("line_hs_width", 64'(n_hs_line), 64'(HS));
        chk("line_de_width", 64'(n_de_line), 64'(HD));
        chk("frame_hs_cycles", 64'(n_hs), 64'(HS * VT));
        chk("frame_vs_cycles", 64'(n_vs), 64'(VS * HT));
        chk("frame_de_cycles", 64'(n_de), 64'(HD * VD));
        chk("frame_req_cycles", 64'(n_req), 64'(HD * VD));
        chk("frame_lines", 64'(n_hs_edges), 64'(VT));
        chk("frame_de_lines", 64'(n_de_edges), 64'(VD));
        chk("frame_start_count", 64'(n_fs), 64'd1);
        chk("frame_start_period", 64'(fs_k - 16145), 64'(FRAME));

        // Mid-line reset inside an active row.
        guard = 0;
        while (!(data_req && pixel_ypos == 10'd4 && pixel_xpos == 10'd300) && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        chk("midline_trigger_found", 64'(guard < 30000), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_midline", {28'd0, get_obs(), lcd_r, lcd_g, lcd_b}, {28'd0, rst_obs, 12'h000});
        rst = 1'b0;

        kd = -1; ke = -1; guard = 0;
        while (ke < 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (k == PL + 2) chk("restart_hs_active", 64'(lcd_hs), 64'd0);
            if (data_req && kd < 0) begin
                kd = k;
                chk("restart_first_fs", 64'(frame_start), 64'd1);
                chk("restart_first_xy", {44'd0, pixel_xpos, pixel_ypos}, 64'd0);
            end
            if (lcd_de) ke = k;
        end
        chk("restart_first_req_clk", 64'(kd), 64'(VAS * HT + HAS + 1));
        chk("restart_first_de_clk", 64'(ke), 64'(VAS * HT + HAS + PL + 2));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
